// File: rtl/pulse_stretch_tx.sv
// pulse_stretch_tx: source-domain pulse stretcher feeding a two-FF pulse synchronizer.
// Each accepted strobe becomes STRETCH_LEN cycles high followed by GAP_LEN cycles low.
// Strobes arriving while busy are queued in a saturating pending counter; overflowing
// strobes are dropped and flagged on the sticky Overflow output.
// Optional macro PULSE_STRETCH_DROP_CNT_EN adds an 8-bit saturating Drop_cnt output.
module pulse_stretch_tx #(
    parameter int unsigned STRETCH_LEN = 4,
    parameter int unsigned GAP_LEN     = 4,
    parameter int unsigned PEND_W      = 3
) (
    input  logic              Clk,
    input  logic              Reset_b,
    input  logic              Pulse_in,
    input  logic              Clear_ovf,
    output logic              Pulse_out,
    output logic              Busy,
    output logic [PEND_W-1:0] Pending,
    output logic              Overflow
`ifdef PULSE_STRETCH_DROP_CNT_EN
    ,
    output logic [7:0]        Drop_cnt
`endif
);

    localparam int unsigned MAX_LEN = (STRETCH_LEN > GAP_LEN) ? STRETCH_LEN : GAP_LEN;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(STRETCH_LEN);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_LEN);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] phase_cnt;
    logic             gap_end;
    logic             queue_req;
    logic             drop;

    // Classify the incoming strobe: consumed at gap end, queued, or dropped.
    always_comb begin
        gap_end   = 1'b0;
        queue_req = 1'b0;
        drop      = 1'b0;
        gap_end   = (state == ST_GAP) && (phase_cnt == CNT_ONE);
        queue_req = Pulse_in && (state != ST_IDLE) && !gap_end;
        drop      = queue_req && (Pending == PEND_MAX);
    end

    assign Busy = (state != ST_IDLE) || (Pending != '0);

    // Phase FSM with registered Pulse_out, pending queue and sticky overflow.
    always_ff @(posedge Clk or negedge Reset_b) begin
        if (!Reset_b) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
            Pulse_out <= 1'b0;
            Pending   <= '0;
            Overflow  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Pulse_in) begin
                        state     <= ST_HIGH;
                        phase_cnt <= HIGH_LOAD;
                        Pulse_out <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (phase_cnt == CNT_ONE) begin
                        state     <= ST_GAP;
                        phase_cnt <= GAP_LOAD;
                        Pulse_out <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt - CNT_ONE;
                    end
                end
                ST_GAP: begin
                    if (gap_end) begin
                        if ((Pending != '0) || Pulse_in) begin
                            state     <= ST_HIGH;
                            phase_cnt <= HIGH_LOAD;
                            Pulse_out <= 1'b1;
                        end else begin
                            state     <= ST_IDLE;
                            phase_cnt <= '0;
                        end
                        // Queued strobe launched and a new one arriving cancel out,
                        // so Pending only moves when there is no coincident strobe.
                        if ((Pending != '0) && !Pulse_in) begin
                            Pending <= Pending - PEND_ONE;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - CNT_ONE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    phase_cnt <= '0;
                    Pulse_out <= 1'b0;
                end
            endcase

            if (queue_req && !drop) begin
                Pending <= Pending + PEND_ONE;
            end

            if (drop) begin
                Overflow <= 1'b1;
            end else if (Clear_ovf) begin
                Overflow <= 1'b0;
            end
        end
    end

`ifdef PULSE_STRETCH_DROP_CNT_EN
    // Saturating count of dropped strobes; a drop coincident with a clear loads 1.
    always_ff @(posedge Clk or negedge Reset_b) begin
        if (!Reset_b) begin
            Drop_cnt <= '0;
        end else if (drop) begin
            if (Clear_ovf) begin
                Drop_cnt <= 8'd1;
            end else if (Drop_cnt != '1) begin
                Drop_cnt <= Drop_cnt + 8'd1;
            end
        end else if (Clear_ovf) begin
            Drop_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_pulse_stretch_tx.sv
// tb_pulse_stretch_tx: directed self-checking bench for pulse_stretch_tx (defaults 4/4/3).
module tb_pulse_stretch_tx;

    logic       Clk = 1'b0;
    logic       Reset_b = 1'b0;
    logic       Pulse_in = 1'b0;
    logic       Clear_ovf = 1'b0;
    logic       Pulse_out;
    logic       Busy;
    logic [2:0] Pending;
    logic       Overflow;
`ifdef PULSE_STRETCH_DROP_CNT_EN
    logic [7:0] Drop_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    pulse_stretch_tx #(
        .STRETCH_LEN(4),
        .GAP_LEN    (4),
        .PEND_W     (3)
    ) dut (
        .Clk      (Clk),
        .Reset_b  (Reset_b),
        .Pulse_in (Pulse_in),
        .Clear_ovf(Clear_ovf),
        .Pulse_out(Pulse_out),
        .Busy     (Busy),
        .Pending  (Pending),
        .Overflow (Overflow)
`ifdef PULSE_STRETCH_DROP_CNT_EN
        ,
        .Drop_cnt (Drop_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset_b = 1'b0;
        #3;
        tests_run++;
        if ({Pulse_out, Busy, Pending, Overflow} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b required 000000", {Pulse_out, Busy, Pending, Overflow});
        end
        @(negedge Clk);
        Reset_b = 1'b1;
        tick();
        tests_run++;
        if ({Pulse_out, Busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got %b required 00", {Pulse_out, Busy});
        end
    endtask

    // Strobe, then 4 cycles high and 4 low, then idle.
    task automatic test_single();
        Pulse_in = 1'b1;
        tick();
        Pulse_in = 1'b0;
        for (int o = 0; o < 8; o++) begin
            tests_run++;
            if (Pulse_out !== (o < 4) || Busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL single_window[%0d]: got pulse=%b busy=%b required pulse=%b busy=1",
                         o, Pulse_out, Busy, (o < 4));
            end
            tick();
        end
        tests_run++;
        if (Pulse_out !== 1'b0 || Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_idle: got pulse=%b busy=%b required 0 0", Pulse_out, Busy);
        end
    endtask

    task automatic test_three_strobes();
        int peak;
        peak = 0;
        Pulse_in = 1'b1;
        tick();
        for (int o = 0; o < 24; o++) begin
            Pulse_in = (o < 2);
            tests_run++;
            if (Pulse_out !== ((o % 8) < 4)) begin
                tests_failed++;
                $display("FAIL three_window[%0d]: got %b required %b", o, Pulse_out, ((o % 8) < 4));
            end
            if (int'(Pending) > peak) peak = int'(Pending);
            tick();
        end
        Pulse_in = 1'b0;
        tests_run++;
        if (peak != 2) begin
            tests_failed++;
            $display("FAIL three_pending_peak: got %0d required 2", peak);
        end
        tests_run++;
        if (Overflow !== 1'b0 || Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL three_end: got ovf=%b busy=%b required 0 0", Overflow, Busy);
        end
    endtask

    // Strobe on the final gap cycle with nothing queued starts the next window directly.
    task automatic test_gap_end_empty();
        Pulse_in = 1'b1;
        tick();
        Pulse_in = 1'b0;
        repeat (7) tick();
        Pulse_in = 1'b1;
        tick();
        Pulse_in = 1'b0;
        tests_run++;
        if (Pulse_out !== 1'b1 || Pending !== 3'd0) begin
            tests_failed++;
            $display("FAIL gap_end_empty: got pulse=%b pending=%0d required 1 0", Pulse_out, Pending);
        end
        for (int i = 0; i < 100 && Busy; i++) tick();
        tests_run++;
        if (Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL gap_end_empty_drain: got busy=%b required 0", Busy);
        end
    endtask

    // Ten back-to-back strobes, then saturated gap-end strobe and overflow clear cases.
    task automatic test_burst_overflow();
        Pulse_in = 1'b1;
        repeat (10) tick();
        Pulse_in = 1'b0;
        tests_run++;
        if (Pending !== 3'd7 || Overflow !== 1'b1 || Pulse_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL burst_state: got pending=%0d ovf=%b pulse=%b required 7 1 1",
                     Pending, Overflow, Pulse_out);
        end
`ifdef PULSE_STRETCH_DROP_CNT_EN
        tests_run++;
        if (Drop_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL burst_drop_cnt: got %0d required 1", Drop_cnt);
        end
`endif
        Clear_ovf = 1'b1;
        tick();
        Clear_ovf = 1'b0;
        tests_run++;
        if (Overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_ovf: got %b required 0", Overflow);
        end
        repeat (5) tick();
        Pulse_in = 1'b1;
        tick();
        Pulse_in = 1'b0;
        tests_run++;
        if (Pending !== 3'd7 || Overflow !== 1'b0 || Pulse_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL gap_end_saturated: got pending=%0d ovf=%b pulse=%b required 7 0 1",
                     Pending, Overflow, Pulse_out);
        end
        tick();
        Pulse_in = 1'b1;
        Clear_ovf = 1'b1;
        tick();
        Pulse_in = 1'b0;
        Clear_ovf = 1'b0;
        tests_run++;
        if (Overflow !== 1'b1 || Pending !== 3'd7) begin
            tests_failed++;
            $display("FAIL clear_vs_drop: got ovf=%b pending=%0d required 1 7", Overflow, Pending);
        end
`ifdef PULSE_STRETCH_DROP_CNT_EN
        tests_run++;
        if (Drop_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL clear_vs_drop_cnt: got %0d required 1", Drop_cnt);
        end
`endif
        repeat (3) tick();
        tests_run++;
        if (Overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_sticky: got %b required 1", Overflow);
        end
        for (int i = 0; i < 200 && Busy; i++) tick();
        tests_run++;
        if (Busy !== 1'b0 || Pending !== 3'd0) begin
            tests_failed++;
            $display("FAIL burst_drain: got busy=%b pending=%0d required 0 0", Busy, Pending);
        end
    endtask

    task automatic test_async_reset();
        Pulse_in = 1'b1;
        repeat (4) tick();
        Pulse_in = 1'b0;
        tests_run++;
        if (Pulse_out !== 1'b1 || Pending !== 3'd3 || Overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset: got pulse=%b pending=%0d ovf=%b required 1 3 1",
                     Pulse_out, Pending, Overflow);
        end
        #2;
        Reset_b = 1'b0;
        #1;
        tests_run++;
        if ({Pulse_out, Busy, Pending, Overflow} !== 6'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got %b required 000000", {Pulse_out, Busy, Pending, Overflow});
        end
        @(negedge Clk);
        Reset_b = 1'b1;
        tick();
        test_single();
    endtask

    initial begin
        test_reset();
        repeat (3) tick();
        test_single();
        repeat (2) tick();
        test_three_strobes();
        repeat (2) tick();
        test_gap_end_empty();
        repeat (2) tick();
        test_burst_overflow();
        repeat (2) tick();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
